debounced_button_gate: RTL and testbench



---
 rtl/debounced_button_gate.sv | 74 +++++++
 tb/tb_debounced_button_gate.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/debounced_button_gate.sv
// rtl/debounced_button_gate.sv - per-channel synchronised, debounced active-low buttons with press pulses and a mode-selected combined LED
module debounced_button_gate #(
    parameter int N_BTN           = 2,
    parameter int DEBOUNCE_CYCLES = 12000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] pmod,
    input  logic [1:0]       mode,
    output logic [N_BTN:0]   led,
    output logic [N_BTN-1:0] press_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync2;
    logic [N_BTN-1:0] pressed;
    logic [N_BTN-1:0] db;
    logic [N_BTN-1:0] db_prev;
    logic             t;
    logic [CW-1:0]    cnt [N_BTN];
    logic             combined;

    // Pins are active-low; the synchroniser idles at "released".
    assign pressed = ~sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= '1;
            sync2   <= '1;
            db      <= '0;
            db_prev <= '0;
            t       <= 1'b0;
            for (int i = 0; i < N_BTN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1   <= pmod;
            sync2   <= sync1;
            db_prev <= db;
            if (|press_pulse) begin
                t <= ~t;
            end
            // Any sample agreeing with the accepted level restarts the count.
            for (int i = 0; i < N_BTN; i++) begin
                if (pressed[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    db[i]  <= pressed[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    assign press_pulse = db & ~db_prev;

    always_comb begin
        combined = 1'b0;
        case (mode)
            2'b00:   combined = &db;
            2'b01:   combined = |db;
            2'b10:   combined = ^db;
            default: combined = t;
        endcase
    end

    assign led = {combined, db};

endmodule

// File: tb/tb_debounced_button_gate.sv
// tb/tb_debounced_button_gate.sv - directed and randomized checks of debounced_button_gate against a sliding-window model
module tb_debounced_button_gate;

    localparam int N = 2;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] pmod;
    logic [1:0]   mode;
    logic [N:0]   led;
    logic [N-1:0] press_pulse;

    int compared   = 0;
    int mismatched = 0;

    // Model: pin history per edge; db flips once the D most recent synchronised samples all disagree with it.
    logic [N-1:0] p [0:8191];
    int           e = 16;
    logic [N-1:0] m_db  = '0;
    logic [N-1:0] m_dbp = '0;
    logic         m_t   = 1'b0;

    debounced_button_gate #(.N_BTN(N), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .rst(rst), .pmod(pmod), .mode(mode),
        .led(led), .press_pulse(press_pulse)
    );

    always #5 clk = ~clk;

    function automatic logic [N:0] exp_led();
        logic c;
        case (mode)
            2'b00:   c = &m_db;
            2'b01:   c = |m_db;
            2'b10:   c = ^m_db;
            default: c = m_t;
        endcase
        return {c, m_db};
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_edge();
        logic [N-1:0] nd;
        logic         all_diff;
        e++;
        if (rst) begin
            p[e]   = '1;
            p[e-1] = '1;
            m_db   = '0;
            m_dbp  = '0;
            m_t    = 1'b0;
        end else begin
            p[e] = pmod;
            nd   = m_db;
            for (int i = 0; i < N; i++) begin
                all_diff = 1'b1;
                for (int k = 0; k < D; k++) begin
                    if (!p[e-2-k][i] == m_db[i]) all_diff = 1'b0;
                end
                if (all_diff) nd[i] = ~m_db[i];
            end
            if (|(m_db & ~m_dbp)) m_t = ~m_t;
            m_dbp = m_db;
            m_db  = nd;
        end
    endtask

    task automatic step(input logic r, input logic [N-1:0] pins);
        rst  = r;
        pmod = pins;
        @(posedge clk);
        model_edge();
        #1;
        check("led", 8'(led), 8'(exp_led()));
        check("press_pulse", 8'(press_pulse), 8'(m_db & ~m_dbp));
    endtask

    task automatic set_mode(input logic [1:0] m);
        mode = m;
        #1;
        check("mode_switch", 8'(led), 8'(exp_led()));
    endtask

    initial begin
        rst  = 1'b1;
        pmod = '1;
        mode = 2'b00;

        // Reset with both buttons held, then both accepted on the 6th edge.
        step(1'b1, 2'b00);
        step(1'b1, 2'b00);
        check("reset_led", 8'(led), 8'h00);
        check("reset_pulse", 8'(press_pulse), 8'h00);
        for (int n = 1; n <= 7; n++) begin
            step(1'b0, 2'b00);
            if (n == 5) check("rel_rst_edge5", 8'(led[1:0]), 8'h0);
            if (n == 6) begin
                check("rel_rst_edge6", 8'(led[1:0]), 8'h3);
                check("rel_rst_pulse", 8'(press_pulse), 8'h3);
            end
            if (n == 7) check("rel_rst_pulse_gone", 8'(press_pulse), 8'h0);
        end

        // Clean press and release on ch0.
        repeat (8) step(1'b0, 2'b11);
        for (int n = 1; n <= 6; n++) begin
            step(1'b0, 2'b10);
            if (n == 6) begin
                check("clean_press", 8'(led[0]), 8'h1);
                check("clean_pulse", 8'(press_pulse[0]), 8'h1);
            end
        end
        repeat (3) step(1'b0, 2'b10);
        for (int n = 1; n <= 6; n++) begin
            step(1'b0, 2'b11);
            if (n == 5) check("release_edge5", 8'(led[0]), 8'h1);
            if (n == 6) check("release_edge6", 8'(led[0]), 8'h0);
        end

        // Bounce never reaches D stable samples.
        repeat (3) step(1'b0, 2'b10);
        step(1'b0, 2'b11);
        repeat (3) step(1'b0, 2'b10);
        repeat (4) step(1'b0, 2'b11);
        check("bounce_held_off", 8'(led[0]), 8'h0);
        for (int n = 1; n <= 6; n++) begin
            step(1'b0, 2'b10);
            if (n == 6) check("after_bounce", 8'(led[0]), 8'h1);
        end

        // Combine modes.
        repeat (8) step(1'b0, 2'b00);
        set_mode(2'b00);
        check("and_both", 8'(led[2]), 8'h1);
        set_mode(2'b01);
        check("or_both", 8'(led[2]), 8'h1);
        set_mode(2'b10);
        check("xor_both", 8'(led[2]), 8'h0);
        repeat (6) step(1'b0, 2'b10);
        set_mode(2'b00);
        check("and_one", 8'(led[2]), 8'h0);
        set_mode(2'b10);
        check("xor_one", 8'(led[2]), 8'h1);

        // Toggle: fresh reset gives t=0.
        step(1'b1, 2'b11);
        set_mode(2'b11);
        repeat (6) step(1'b0, 2'b11);
        check("toggle_init", 8'(led[2]), 8'h0);
        repeat (8) step(1'b0, 2'b00);
        check("toggle_once", 8'(led[2]), 8'h1);
        repeat (8) step(1'b0, 2'b11);
        repeat (8) step(1'b0, 2'b01);
        check("toggle_back", 8'(led[2]), 8'h0);

        // Reset mid-count discards the partial transition.
        repeat (8) step(1'b0, 2'b11);
        repeat (3) step(1'b0, 2'b10);
        step(1'b1, 2'b10);
        for (int n = 1; n <= 7; n++) begin
            step(1'b0, 2'b10);
            if (n == 5) check("midrst_no_early", 8'(led[0]), 8'h0);
            if (n == 6) begin
                check("midrst_rise", 8'(led[0]), 8'h1);
                check("midrst_pulse", 8'(press_pulse[0]), 8'h1);
            end
        end

        // Randomized holds, modes and occasional resets.
        for (int r = 0; r < 150; r++) begin
            logic [N-1:0] pins;
            int           hold;
            pins = N'($urandom);
            hold = $urandom_range(1, 8);
            if ($urandom_range(0, 7) == 0) set_mode(2'($urandom));
            for (int h = 0; h < hold; h++) begin
                step(($urandom_range(0, 99) == 0), pins);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
